pcie_ep_cfg_ctrl: RTL and testbench
===================================

Name: pcie_ep_cfg_ctrl

Overview:
Parametrised endpoint configuration and control block. It owns the ID, command/status, BAR, interrupt and GPIO registers behind a request/acknowledge configuration port, and decodes transaction-layer addresses against the BARs. It collects NUM_INT edge-triggered interrupt sources into W1C pending bits and emits them as MSI-style messages via a valid/ready handshake. A level interrupt output is also provided. The block sits between the config-access path and the transaction layer.

Parameters:
NUM_BARS, 2, number of implemented 32-bit memory BARs (1..6)
BAR_SIZE_LOG2, 12, log2 of each BAR's window in bytes (4..31)
NUM_INT, 4, number of interrupt sources/vectors (1..32)
GPIO_W, 8, GPIO width (1..32)
VENDOR_ID, 16'h10EE, read-only vendor ID
DEVICE_ID, 16'h0001, read-only device ID

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset, synchronous, active-high
cfg_req  in  1  config access request, one cycle per access
cfg_we  in  1  1 = write, 0 = read
cfg_addr  in  6  dword index
cfg_wdata  in  32  write data
cfg_be  in  4  byte enables for writes
cfg_ack  out  1  pulses one cycle after each cfg_req
cfg_rdata  out  32  read data, valid while cfg_ack is high; 0 otherwise
tl_addr_valid  in  1  transaction-layer address strobe
tl_addr  in  32  transaction-layer byte address
tl_hit_valid  out  1  registered copy of tl_addr_valid
tl_bar_hit  out  NUM_BARS  one-hot BAR match, qualified by tl_hit_valid
int_in  in  NUM_INT  interrupt sources; rising edge sets pending
int_level  out  1  |(pend & mask) & ~cmd[10]
msg_valid  out  1  interrupt message request
msg_vector  out  5  vector index of the message
msg_ready  in  1  message accepted by the transaction layer
gpio_in  in  GPIO_W  GPIO inputs, double-flopped internally
gpio_out  out  GPIO_W  GPIO output register

Behaviour:
- Reset, applied synchronously: all RW registers 0, pending/sent/edge history 0, FSM to IDLE.
- Output reset values: cfg_ack=0, cfg_rdata=0, tl_hit_valid=0, tl_bar_hit=0, msg_valid=0, msg_vector=0, int_level=0, gpio_out=0.
- Reset asserted mid-message drops msg_valid in the next cycle with no completion.
- Register map (dword index):
  - 0x00 ID: RO {DEVICE_ID, VENDOR_ID}.
  - 0x01: [15:0] cmd RW, with bits 1 (mem enable), 2 (bus master) and 10 (int disable) implemented and all others reading 0. [31:16] status RO; status bit 3 reflects int_level before the disable gate.
  - 0x02..0x07 BARn: bits [31:BAR_SIZE_LOG2] RW, bits below read 0. Writing all-ones reads back ~(2^BAR_SIZE_LOG2-1). Indices at or above 0x02+NUM_BARS read 0 and ignore writes.
  - 0x08 INT_PEND: W1C on [NUM_INT-1:0].
  - 0x09 INT_MASK: RW.
  - 0x0A GPIO_OUT: RW.
  - 0x0B GPIO_IN: RO, synchronised value.
  - All other indices read 0 and ignore writes.
- Config writes honour cfg_be per byte, including on W1C.
- Access latency: fixed at 1 cycle. Back-to-back requests are legal. A read observes state from before a same-cycle write.
- Pending bit set and W1C clear in the same cycle: set wins.
- Edge detect: a pending bit sets when int_in is 1 and was 0 in the previous cycle. A held-high input sets it only once.
- BAR decode: tl_bar_hit[n] = 1 when tl_addr[31:BAR_SIZE_LOG2] == BARn[31:BAR_SIZE_LOG2] and cmd[1] = 1. It is registered, 1-cycle latency. A BAR value of 0 never hits.
- Message FSM, using cand = pend & mask & ~sent:
  - IDLE: if cmd[2] = 1 and cand != 0, latch msg_vector = lowest set index of cand and go to SEND.
  - SEND: msg_valid = 1; msg_vector is stable. On msg_ready, set sent[vec] and go to GAP.
  - SEND is not abandoned even if the mask or pending bit clears while waiting.
  - GAP: one idle cycle for re-arbitration, then back to IDLE.
- sent[i] clears whenever pend[i] clears. Each pending assertion therefore produces exactly one message.
- cmd[2] = 0 holds the FSM in IDLE; pending bits keep accumulating.
- msg_vector[4:0] is zero-extended when NUM_INT < 32.

Decomposition:
- Package pcie_ep_pkg holds:
  - register index localparams (ID, CMDSTS, BAR0, INT_PEND, INT_MASK, GPIO_OUT, GPIO_IN);
  - cmd bit positions (MEM_EN = 1, BUS_MASTER = 2, INT_DIS = 10);
  - the message FSM enum typedef {IDLE, SEND, GAP}.
- One sub-module, pcie_ep_int_ctrl, contains the edge detect, pending/mask/sent vectors, priority encoder and message FSM. The top level keeps the register file, config port and BAR decode.

Test Plan:
- After reset, read 0x00 → rdata 32'h0001_10EE with ack exactly 1 cycle after req. Read 0x01 → 0.
- BAR sizing: write 0x02 = 32'hFFFF_FFFF → read 32'hFFFF_F000. Write 32'h8000_0000 and cmd = 16'h0002, then tl_addr 32'h8000_0FFC → tl_bar_hit = 2'b01 one cycle later. tl_addr 32'h8000_1000 → 2'b00.
- Messages: mask = 4'hF, cmd = 16'h0004. Pulse int_in[2] and int_in[1] in the same cycle → messages vector 1 then vector 2, each held until msg_ready, with a 1-cycle gap between them. No resend until W1C.
- With msg_ready held low for 5 cycles, msg_valid and msg_vector stay constant.
- W1C: write 0x08 = 32'h4 with be = 4'h1 in the same cycle as a new rising edge on int_in[2] → pend[2] stays 1 and a second message for vector 2 follows.
- Apply reset while in SEND → msg_valid = 0 in the next cycle, and pend, mask and gpio_out read 0.
- Write 0x0A = 32'hA5 with be = 4'h1 → gpio_out = 8'hA5. Drive gpio_in = 8'h3C → a read of 0x0B returns 8'h3C within 3 cycles.

Source files
------------

// File: rtl/pcie_ep_pkg.sv
// rtl/pcie_ep_pkg.sv - shared register map, command bits and message FSM states
// for the endpoint configuration block.
package pcie_ep_pkg;

    localparam logic [5:0] REG_ID       = 6'h00;
    localparam logic [5:0] REG_CMDSTS   = 6'h01;
    localparam logic [5:0] REG_BAR0     = 6'h02;
    localparam logic [5:0] REG_INT_PEND = 6'h08;
    localparam logic [5:0] REG_INT_MASK = 6'h09;
    localparam logic [5:0] REG_GPIO_OUT = 6'h0A;
    localparam logic [5:0] REG_GPIO_IN  = 6'h0B;

    localparam int CMD_MEM_EN     = 1;
    localparam int CMD_BUS_MASTER = 2;
    localparam int CMD_INT_DIS    = 10;

    // Only the implemented command bits are storable; the rest read as zero.
    localparam logic [15:0] CMD_IMPL_MASK = 16'h0406;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } msg_state_e;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/pcie_ep_int_ctrl.sv
// rtl/pcie_ep_int_ctrl.sv - edge-triggered interrupt pending/sent tracking and
// MSI-style message FSM with lowest-index-first arbitration.
module pcie_ep_int_ctrl #(
    parameter int NUM_INT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] int_in,
    input  logic [NUM_INT-1:0] mask,
    input  logic [NUM_INT-1:0] w1c,
    input  logic               bus_master,
    input  logic               msg_ready,
    output logic [NUM_INT-1:0] pend,
    output logic               irq,
    output logic               msg_valid,
    output logic [4:0]         msg_vector
);
    import pcie_ep_pkg::*;

    logic [NUM_INT-1:0] int_prev_q;
    logic [NUM_INT-1:0] pend_q, pend_d;
    logic [NUM_INT-1:0] sent_q, sent_d;
    logic [NUM_INT-1:0] rise, cand, sent_set;
    logic [4:0]         vec_q, vec_d;
    msg_state_e         state_q, state_d;

    function automatic logic [4:0] lowest_set(input logic [NUM_INT-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    always_comb begin
        rise     = int_in & ~int_prev_q;
        pend_d   = (pend_q & ~w1c) | rise;
        cand     = pend_q & mask & ~sent_q;
        state_d  = state_q;
        vec_d    = vec_q;
        sent_set = '0;
        msg_valid = 1'b0;
        case (state_q)
            // GAP re-arbitrates so consecutive messages are separated by one cycle.
            IDLE, GAP: begin
                if (bus_master && (|cand)) begin
                    vec_d   = lowest_set(cand);
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                msg_valid = 1'b1;
                if (msg_ready) begin
                    for (int i = 0; i < NUM_INT; i++) begin
                        if (vec_q == 5'(i)) sent_set[i] = 1'b1;
                    end
                    state_d = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge re-arms the vector even if the pending bit never dropped.
        sent_d = (sent_q | sent_set) & pend_d & ~rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_prev_q <= '0;
            pend_q     <= '0;
            sent_q     <= '0;
            vec_q      <= '0;
            state_q    <= IDLE;
        end else begin
            int_prev_q <= int_in;
            pend_q     <= pend_d;
            sent_q     <= sent_d;
            vec_q      <= vec_d;
            state_q    <= state_d;
        end
    end

    assign pend       = pend_q;
    assign irq        = |(pend_q & mask);
    assign msg_vector = vec_q;

endmodule

// File: rtl/pcie_ep_cfg_ctrl.sv
// rtl/pcie_ep_cfg_ctrl.sv - endpoint config register file, config port,
// BAR address decode and GPIO; interrupts delegated to pcie_ep_int_ctrl.
module pcie_ep_cfg_ctrl #(
    parameter int          NUM_BARS      = 2,
    parameter int          BAR_SIZE_LOG2 = 12,
    parameter int          NUM_INT       = 4,
    parameter int          GPIO_W        = 8,
    parameter logic [15:0] VENDOR_ID     = 16'h10EE,
    parameter logic [15:0] DEVICE_ID     = 16'h0001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_req,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    input  logic [3:0]          cfg_be,
    output logic                cfg_ack,
    output logic [31:0]         cfg_rdata,
    input  logic                tl_addr_valid,
    input  logic [31:0]         tl_addr,
    output logic                tl_hit_valid,
    output logic [NUM_BARS-1:0] tl_bar_hit,
    input  logic [NUM_INT-1:0]  int_in,
    output logic                int_level,
    output logic                msg_valid,
    output logic [4:0]          msg_vector,
    input  logic                msg_ready,
    input  logic [GPIO_W-1:0]   gpio_in,
    output logic [GPIO_W-1:0]   gpio_out
);
    import pcie_ep_pkg::*;

    localparam logic [31:0] BAR_MASK = ~((32'h1 << BAR_SIZE_LOG2) - 32'h1);

    logic [15:0]         cmd_q, cmd_d;
    logic [31:0]         bar_q [NUM_BARS];
    logic [31:0]         bar_d [NUM_BARS];
    logic [NUM_INT-1:0]  mask_q, mask_d, w1c, pend;
    logic [GPIO_W-1:0]   gpio_out_q, gpio_out_d, gpio_s1_q, gpio_s2_q;
    logic                cfg_ack_q;
    logic [31:0]         cfg_rdata_q, rd_data, be_mask;
    logic [15:0]         status;
    logic [NUM_BARS-1:0] hit_q, hit_d;
    logic                hit_valid_q, irq_raw, wr_en;

    always_comb begin
        be_mask    = be_to_mask(cfg_be);
        wr_en      = cfg_req & cfg_we;
        cmd_d      = cmd_q;
        mask_d     = mask_q;
        gpio_out_d = gpio_out_q;
        w1c        = '0;
        for (int n = 0; n < NUM_BARS; n++) bar_d[n] = bar_q[n];
        if (wr_en) begin
            if (cfg_addr == REG_CMDSTS)
                cmd_d = ((cmd_q & ~be_mask[15:0]) | (cfg_wdata[15:0] & be_mask[15:0])) & CMD_IMPL_MASK;
            for (int n = 0; n < NUM_BARS; n++) begin
                if (cfg_addr == REG_BAR0 + 6'(n))
                    bar_d[n] = ((bar_q[n] & ~be_mask) | (cfg_wdata & be_mask)) & BAR_MASK;
            end
            for (int i = 0; i < NUM_INT; i++) begin
                if (cfg_addr == REG_INT_MASK) mask_d[i] = be_mask[i] ? cfg_wdata[i] : mask_q[i];
                if (cfg_addr == REG_INT_PEND) w1c[i] = be_mask[i] & cfg_wdata[i];
            end
            for (int i = 0; i < GPIO_W; i++) begin
                if (cfg_addr == REG_GPIO_OUT) gpio_out_d[i] = be_mask[i] ? cfg_wdata[i] : gpio_out_q[i];
            end
        end
    end

    // Reads use pre-write state, so a same-cycle write is not visible.
    always_comb begin
        status  = {12'h000, irq_raw, 3'b000};
        rd_data = '0;
        case (cfg_addr)
            REG_ID:       rd_data = {DEVICE_ID, VENDOR_ID};
            REG_CMDSTS:   rd_data = {status, cmd_q};
            REG_INT_PEND: for (int i = 0; i < NUM_INT; i++) rd_data[i] = pend[i];
            REG_INT_MASK: for (int i = 0; i < NUM_INT; i++) rd_data[i] = mask_q[i];
            REG_GPIO_OUT: for (int i = 0; i < GPIO_W; i++) rd_data[i] = gpio_out_q[i];
            REG_GPIO_IN:  for (int i = 0; i < GPIO_W; i++) rd_data[i] = gpio_s2_q[i];
            default:      rd_data = '0;
        endcase
        for (int n = 0; n < NUM_BARS; n++) begin
            if (cfg_addr == REG_BAR0 + 6'(n)) rd_data = bar_q[n];
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_BARS; n++) begin
            hit_d[n] = tl_addr_valid & cmd_q[CMD_MEM_EN] & (bar_q[n] != 32'h0)
                     & ((tl_addr & BAR_MASK) == bar_q[n]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= '0;
            mask_q      <= '0;
            gpio_out_q  <= '0;
            gpio_s1_q   <= '0;
            gpio_s2_q   <= '0;
            cfg_ack_q   <= 1'b0;
            cfg_rdata_q <= '0;
            hit_q       <= '0;
            hit_valid_q <= 1'b0;
            for (int n = 0; n < NUM_BARS; n++) bar_q[n] <= '0;
        end else begin
            cmd_q       <= cmd_d;
            mask_q      <= mask_d;
            gpio_out_q  <= gpio_out_d;
            gpio_s1_q   <= gpio_in;
            gpio_s2_q   <= gpio_s1_q;
            cfg_ack_q   <= cfg_req;
            cfg_rdata_q <= (cfg_req && !cfg_we) ? rd_data : 32'h0;
            hit_q       <= hit_d;
            hit_valid_q <= tl_addr_valid;
            for (int n = 0; n < NUM_BARS; n++) bar_q[n] <= bar_d[n];
        end
    end

    pcie_ep_int_ctrl #(
        .NUM_INT(NUM_INT)
    ) u_int_ctrl (
        .clk        (clk),
        .rst        (rst),
        .int_in     (int_in),
        .mask       (mask_q),
        .w1c        (w1c),
        .bus_master (cmd_q[CMD_BUS_MASTER]),
        .msg_ready  (msg_ready),
        .pend       (pend),
        .irq        (irq_raw),
        .msg_valid  (msg_valid),
        .msg_vector (msg_vector)
    );

    assign cfg_ack      = cfg_ack_q;
    assign cfg_rdata    = cfg_rdata_q;
    assign tl_hit_valid = hit_valid_q;
    assign tl_bar_hit   = hit_q;
    assign int_level    = irq_raw & ~cmd_q[CMD_INT_DIS];
    assign gpio_out     = gpio_out_q;

endmodule

// File: tb/tb_pcie_ep_cfg_ctrl.sv
// tb/tb_pcie_ep_cfg_ctrl.sv - directed self-checking bench for pcie_ep_cfg_ctrl.
module tb_pcie_ep_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req, cfg_we;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [3:0]  cfg_be;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;
    logic        tl_addr_valid;
    logic [31:0] tl_addr;
    logic        tl_hit_valid;
    logic [1:0]  tl_bar_hit;
    logic [3:0]  int_in;
    logic        int_level;
    logic        msg_valid;
    logic [4:0]  msg_vector;
    logic        msg_ready;
    logic [7:0]  gpio_in, gpio_out;

    int checks = 0;
    int errors = 0;

    pcie_ep_cfg_ctrl #(
        .NUM_BARS(2), .BAR_SIZE_LOG2(12), .NUM_INT(4), .GPIO_W(8),
        .VENDOR_ID(16'h10EE), .DEVICE_ID(16'h0001)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_be(cfg_be), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
        .tl_addr_valid(tl_addr_valid), .tl_addr(tl_addr),
        .tl_hit_valid(tl_hit_valid), .tl_bar_hit(tl_bar_hit),
        .int_in(int_in), .int_level(int_level),
        .msg_valid(msg_valid), .msg_vector(msg_vector), .msg_ready(msg_ready),
        .gpio_in(gpio_in), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; cfg_be = be;
        tick();
        cfg_req = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_rd(input logic [5:0] a, output logic [31:0] d);
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        tick();
        d = cfg_rdata;
        cfg_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_req = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_be = 0;
        tl_addr_valid = 0; tl_addr = 0; int_in = 0; msg_ready = 0; gpio_in = 0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", cfg_ack); end
        checks++; if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", cfg_rdata); end
        checks++; if (tl_hit_valid !== 1'b0 || tl_bar_hit !== 2'b00) begin errors++; $display("FAIL rst_tl got %b/%b exp 0/00", tl_hit_valid, tl_bar_hit); end
        checks++; if (msg_valid !== 1'b0 || msg_vector !== 5'd0) begin errors++; $display("FAIL rst_msg got %b/%0d exp 0/0", msg_valid, msg_vector); end
        checks++; if (int_level !== 1'b0 || gpio_out !== 8'h00) begin errors++; $display("FAIL rst_lvl_gpio got %b/%h exp 0/00", int_level, gpio_out); end
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 6'h00;
        #1;
        checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL ack_early got %b exp 0", cfg_ack); end
        tick();
        cfg_req = 1'b0;
        checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL ack_latency got %b exp 1", cfg_ack); end
        checks++; if (cfg_rdata !== 32'h0001_10EE) begin errors++; $display("FAIL id_read got %h exp 000110ee", cfg_rdata); end
        tick();
        checks++; if (cfg_ack !== 1'b0 || cfg_rdata !== 32'h0) begin errors++; $display("FAIL ack_drop got %b/%h exp 0/0", cfg_ack, cfg_rdata); end
    endtask

    task automatic test_regs_after_reset();
        logic [31:0] d;
        cfg_rd(6'h01, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL cmdsts_rst got %h exp 0", d); end
        cfg_rd(6'h03, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL bar1_rst got %h exp 0", d); end
    endtask

    task automatic test_bar();
        logic [31:0] d;
        cfg_wr(6'h02, 32'hFFFF_FFFF, 4'hF);
        cfg_rd(6'h02, d);
        checks++; if (d !== 32'hFFFF_F000) begin errors++; $display("FAIL bar_size got %h exp fffff000", d); end
        cfg_wr(6'h04, 32'hFFFF_FFFF, 4'hF);
        cfg_rd(6'h04, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL bar_unimpl got %h exp 0", d); end
        cfg_wr(6'h02, 32'h8000_0000, 4'hF);
        cfg_wr(6'h01, 32'h0000_0002, 4'hF);
        cfg_rd(6'h01, d);
        checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL cmd_mem_en got %h exp 00000002", d); end
        tl_addr_valid = 1'b1; tl_addr = 32'h8000_0FFC;
        tick();
        checks++; if (tl_hit_valid !== 1'b1 || tl_bar_hit !== 2'b01) begin errors++; $display("FAIL bar_hit_top got %b/%b exp 1/01", tl_hit_valid, tl_bar_hit); end
        tl_addr = 32'h8000_1000;
        tick();
        checks++; if (tl_hit_valid !== 1'b1 || tl_bar_hit !== 2'b00) begin errors++; $display("FAIL bar_miss_next got %b/%b exp 1/00", tl_hit_valid, tl_bar_hit); end
        tl_addr_valid = 1'b0;
        cfg_wr(6'h01, 32'h0, 4'hF);
        tl_addr_valid = 1'b1; tl_addr = 32'h8000_0000;
        tick();
        checks++; if (tl_bar_hit !== 2'b00) begin errors++; $display("FAIL bar_mem_dis got %b exp 00", tl_bar_hit); end
        tl_addr_valid = 1'b0;
        tick();
        checks++; if (tl_hit_valid !== 1'b0) begin errors++; $display("FAIL hit_valid_drop got %b exp 0", tl_hit_valid); end
        cfg_wr(6'h02, 32'h1234_5678, 4'h8);
        cfg_rd(6'h02, d);
        checks++; if (d !== 32'h1200_0000) begin errors++; $display("FAIL bar_be got %h exp 12000000", d); end
    endtask

    task automatic test_msg();
        logic [31:0] d;
        cfg_wr(6'h09, 32'hF, 4'hF);
        cfg_wr(6'h01, 32'h0004, 4'hF);
        int_in = 4'b0110;
        tick();
        int_in = 4'b0000;
        checks++; if (int_level !== 1'b1) begin errors++; $display("FAIL int_level_on got %b exp 1", int_level); end
        tick();
        checks++; if (msg_valid !== 1'b1 || msg_vector !== 5'd1) begin errors++; $display("FAIL msg_first got %b/%0d exp 1/1", msg_valid, msg_vector); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (msg_valid !== 1'b1 || msg_vector !== 5'd1) begin errors++; $display("FAIL msg_hold%0d got %b/%0d exp 1/1", i, msg_valid, msg_vector); end
        end
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL msg_gap got %b exp 0", msg_valid); end
        tick();
        checks++; if (msg_valid !== 1'b1 || msg_vector !== 5'd2) begin errors++; $display("FAIL msg_second got %b/%0d exp 1/2", msg_valid, msg_vector); end
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL no_resend%0d got %b exp 0", i, msg_valid); end
        end
        cfg_rd(6'h08, d);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL pend_after_msg got %h exp 6", d); end
        cfg_wr(6'h01, 32'h0404, 4'hF);
        checks++; if (int_level !== 1'b0) begin errors++; $display("FAIL int_disable got %b exp 0", int_level); end
        cfg_rd(6'h01, d);
        checks++; if (d !== 32'h0008_0404) begin errors++; $display("FAIL status_bit3 got %h exp 00080404", d); end
        cfg_wr(6'h01, 32'h0004, 4'hF);
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 6'h08; cfg_wdata = 32'h4; cfg_be = 4'h1;
        int_in = 4'b0100;
        tick();
        cfg_req = 1'b0; cfg_we = 1'b0; int_in = 4'b0000;
        cfg_rd(6'h08, d);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL w1c_set_wins got %h exp 6", d); end
        checks++; if (msg_valid !== 1'b1 || msg_vector !== 5'd2) begin errors++; $display("FAIL msg_rearm got %b/%0d exp 1/2", msg_valid, msg_vector); end
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        cfg_wr(6'h08, 32'h4, 4'h2);
        cfg_rd(6'h08, d);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL w1c_be_off got %h exp 6", d); end
        cfg_wr(6'h08, 32'h6, 4'h1);
        cfg_rd(6'h08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h exp 0", d); end
        checks++; if (int_level !== 1'b0 || msg_valid !== 1'b0) begin errors++; $display("FAIL w1c_idle got %b/%b exp 0/0", int_level, msg_valid); end
    endtask

    task automatic test_gpio();
        logic [31:0] d;
        cfg_wr(6'h0A, 32'hA5, 4'h1);
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL gpio_out got %h exp a5", gpio_out); end
        cfg_wr(6'h0A, 32'hFF, 4'h2);
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL gpio_be_off got %h exp a5", gpio_out); end
        gpio_in = 8'h3C;
        tick(); tick();
        cfg_rd(6'h0B, d);
        checks++; if (d !== 32'h3C) begin errors++; $display("FAIL gpio_in got %h exp 3c", d); end
    endtask

    task automatic test_reset_mid_send();
        logic [31:0] d;
        int_in = 4'b0001;
        tick();
        int_in = 4'b0000;
        tick();
        checks++; if (msg_valid !== 1'b1 || msg_vector !== 5'd0) begin errors++; $display("FAIL pre_rst_send got %b/%0d exp 1/0", msg_valid, msg_vector); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (msg_valid !== 1'b0 || gpio_out !== 8'h00) begin errors++; $display("FAIL rst_mid_send got %b/%h exp 0/00", msg_valid, gpio_out); end
        cfg_rd(6'h08, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pend got %h exp 0", d); end
        cfg_rd(6'h09, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mask got %h exp 0", d); end
        cfg_rd(6'h0A, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_gpio_reg got %h exp 0", d); end
    endtask

    initial begin
        test_reset();
        test_regs_after_reset();
        test_bar();
        test_msg();
        test_w1c();
        test_gpio();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
